// File: rtl/sync_bit_filter.sv
// Multi-channel level synchronizer with a per-bit stability filter,
// edge pulses and sticky event flags.
module sync_bit_filter #(
    parameter int                   N             = 2,
    parameter int                   BUS_WIDTH     = 4,
    parameter int                   FILTER_CYCLES = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_VAL     = {BUS_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic [BUS_WIDTH-1:0] evt_clr,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic [BUS_WIDTH-1:0] rise,
    output logic [BUS_WIDTH-1:0] fall,
    output logic [BUS_WIDTH-1:0] evt_sticky,
    output logic                 any_evt
);

    localparam int             CW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = CW'(FILTER_CYCLES);

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [N-1:0][BUS_WIDTH-1:0]  sync_q;
    logic [N-1:0][BUS_WIDTH-1:0]  sync_d;
    logic [BUS_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]         data_out_q, data_out_d;
    logic [BUS_WIDTH-1:0]         rise_q, rise_d;
    logic [BUS_WIDTH-1:0]         fall_q, fall_d;
    logic [BUS_WIDTH-1:0]         sticky_q, sticky_d;
    logic [BUS_WIDTH-1:0]         chain;
    logic [BUS_WIDTH-1:0]         mism;
    logic [BUS_WIDTH-1:0]         accept;

    always_comb begin
        sync_d[0] = data_in;
        for (int k = 1; k < N; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        chain = sync_q[N-1];
        mism  = chain ^ data_out_q;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            accept[i] = mism[i] && (cnt_q[i] == LAST);
            // Matching edge or accepted change restarts the stability count
            if (!mism[i] || accept[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= MAX) begin
                cnt_d[i] = MAX;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        data_out_d = data_out_q ^ accept;
        rise_d     = accept & chain;
        fall_d     = accept & ~chain;
        // A new event wins over a simultaneous clear
        sticky_d   = rise_d | fall_d | (sticky_q & ~evt_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= {N{RESET_VAL}};
            data_out_q <= RESET_VAL;
            cnt_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            sticky_q   <= '0;
        end else begin
            sync_q     <= sync_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            sticky_q   <= sticky_d;
        end
    end

    assign data_out   = data_out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign evt_sticky = sticky_q;
    assign any_evt    = |sticky_q;

endmodule

// File: tb/tb_sync_bit_filter.sv
// Bench for sync_bit_filter: directed vector table, reset and
// independence sequences, then random traffic against a window model.
module tb_sync_bit_filter;

    localparam int         N  = 2;
    localparam int         W  = 4;
    localparam int         F  = 4;
    localparam logic [3:0] RV = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_in;
    logic [3:0] evt_clr;
    logic [3:0] data_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt_sticky;
    logic       any_evt;

    int n_tests = 0;
    int n_fail  = 0;

    sync_bit_filter #(
        .N(N), .BUS_WIDTH(W), .FILTER_CYCLES(F), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .evt_clr(evt_clr), .data_out(data_out), .rise(rise),
        .fall(fall), .evt_sticky(evt_sticky), .any_evt(any_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        bit         r;
        logic [3:0] d, c, o, ri, fa, st;
    } vec_t;

    vec_t tv[$];

    function automatic void add(string nm, bit r,
                                logic [3:0] d, logic [3:0] c,
                                logic [3:0] o, logic [3:0] ri,
                                logic [3:0] fa, logic [3:0] st,
                                int rep);
        vec_t v;
        v.nm = nm; v.r = r; v.d = d; v.c = c;
        v.o = o; v.ri = ri; v.fa = fa; v.st = st;
        repeat (rep) tv.push_back(v);
    endfunction

    function automatic logic [16:0] obs();
        return {any_evt, data_out, rise, fall, evt_sticky};
    endfunction

    function automatic logic [16:0] expv(logic [3:0] o, logic [3:0] ri,
                                         logic [3:0] fa, logic [3:0] st);
        return {|st, o, ri, fa, st};
    endfunction

    task automatic chk(string nm, logic [16:0] act, logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got any/out/rise/fall/sticky=%h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic tick(bit r, logic [3:0] d, logic [3:0] c);
        rst_n   = r;
        data_in = d;
        evt_clr = c;
        @(posedge clk);
        #1;
    endtask

    // Reference: accept a change when the last F synchronized samples
    // (since reset) all disagree with the current output.
    logic [3:0] m_out, m_rise, m_fall, m_st;
    logic [3:0] chq[$];
    logic [3:0] win[$];

    function automatic void model_edge(bit r, logic [3:0] d, logic [3:0] c);
        logic [3:0] acc;
        logic [3:0] nout;
        bit         all;
        if (!r) begin
            m_out = RV; m_rise = '0; m_fall = '0; m_st = '0;
            chq.delete();
            repeat (N) chq.push_back(RV);
            win.delete();
        end else begin
            win.push_back(chq[0]);
            if (win.size() > F) void'(win.pop_front());
            acc = '0;
            if (win.size() == F) begin
                for (int i = 0; i < W; i++) begin
                    all = 1'b1;
                    foreach (win[j]) if (win[j][i] == m_out[i]) all = 1'b0;
                    acc[i] = all;
                end
            end
            nout   = m_out ^ acc;
            m_rise = acc & nout;
            m_fall = acc & ~nout;
            m_st   = m_rise | m_fall | (m_st & ~c);
            m_out  = nout;
            void'(chq.pop_front());
            chq.push_back(d);
        end
    endfunction

    initial begin
        logic [3:0] d;
        logic [3:0] c;
        logic [3:0] flip;
        bit         r;

        rst_n = 1'b0; data_in = '0; evt_clr = '0;
        @(posedge clk);
        #1;

        add("reset",     0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
        add("t1_wait",   1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add("t1_rise",   1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 1);
        add("t1_hold",   1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        add("t2_glitch", 1, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3);
        add("t2_after",  1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 6);
        add("t3_wait",   1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 5);
        add("t3_fall",   1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1);
        add("t3_clr",    1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add("t3_idle",   1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add("t4_wait",   1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add("t4_coll",   1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 1);
        add("t4_hold",   1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 1);

        foreach (tv[k]) begin
            tick(tv[k].r, tv[k].d, tv[k].c);
            chk(tv[k].nm, obs(), expv(tv[k].o, tv[k].ri, tv[k].fa, tv[k].st));
        end

        // Reset in the middle of a pending count
        tick(0, 4'h0, 4'h0);
        tick(0, 4'h0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            tick(1, 4'hF, 4'h0);
            chk("t5_pre", obs(), expv(4'h0, 4'h0, 4'h0, 4'h0));
        end
        tick(0, 4'hF, 4'h0);
        chk("t5_in_reset", obs(), expv(4'h0, 4'h0, 4'h0, 4'h0));
        for (int k = 1; k <= 8; k++) begin
            tick(1, 4'hF, 4'h0);
            chk("t5_release", obs(),
                expv(k >= 6 ? 4'hF : 4'h0, k == 6 ? 4'hF : 4'h0,
                     4'h0, k >= 6 ? 4'hF : 4'h0));
        end

        // Bit 3 toggles too fast to pass; bit 0 steps cleanly
        tick(0, 4'h0, 4'h0);
        tick(0, 4'h0, 4'h0);
        for (int k = 1; k <= 14; k++) begin
            d = {((k / 2) % 2 == 1), 3'b001};
            tick(1, d, 4'h0);
            chk("t6_indep", obs(),
                expv(k >= 6 ? 4'h1 : 4'h0, k == 6 ? 4'h1 : 4'h0,
                     4'h0, k >= 6 ? 4'h1 : 4'h0));
        end

        d = '0;
        for (int k = 0; k < 3000; k++) begin
            r = !((k < 2) || ($urandom_range(0, 299) == 0));
            for (int i = 0; i < W; i++) begin
                flip[i] = ($urandom_range(0, 5) == 0);
                c[i]    = ($urandom_range(0, 9) == 0);
            end
            d = d ^ flip;
            model_edge(r, d, c);
            tick(r, d, c);
            chk("random", obs(), expv(m_out, m_rise, m_fall, m_st));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
